// File: rtl/sdram_row_scheduler_pkg.sv
// Shared types and defaults for the SDRAM row-affinity command scheduler.
package sdram_sched_pkg;

  localparam int DEF_ADDR_W  = 25;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ROW_LSB = 10;

  // One SDRAM command at the default bus widths.
  typedef struct packed {
    logic                  is_write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sdram_cmd_t;

  // Selection classes in falling priority; CLS_NONE means nothing is eligible.
  typedef enum logic [2:0] {
    CLS_URGENT  = 3'd0,
    CLS_STARVED = 3'd1,
    CLS_WR_HIT  = 3'd2,
    CLS_RD_HIT  = 3'd3,
    CLS_WRITE   = 3'd4,
    CLS_READ    = 3'd5,
    CLS_NONE    = 3'd6
  } sched_class_t;

endpackage

// File: rtl/sdram_row_scheduler_if.sv
// Port-FIFO heads on one side, registered EasySDRAM command on the other.
interface sdram_row_scheduler_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16
);
  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_is_write;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_data;
  logic [NUM_PORTS-1:0]             req_urgent;
  logic [NUM_PORTS-1:0]             req_pop;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_is_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [PORT_W-1:0] cmd_port;
  logic              cmd_row_hit;

  // Environment side: FIFO heads and the SDRAM controller.
  modport master (
    output req_valid, req_is_write, req_addr, req_data, req_urgent, cmd_ready,
    input  req_pop, cmd_valid, cmd_is_write, cmd_addr, cmd_data, cmd_port, cmd_row_hit
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_is_write, req_addr, req_data, req_urgent, cmd_ready,
    output req_pop, cmd_valid, cmd_is_write, cmd_addr, cmd_data, cmd_port, cmd_row_hit
  );
endinterface

// File: rtl/sdram_row_scheduler_rr_pick.sv
// Rotating-priority picker: first set mask bit at or above start, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets from far to near so the nearest set bit overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int p;
      p = (int'(start) + k) % N;
      if (mask[p]) begin
        grant    = '0;
        grant[p] = 1'b1;
        idx      = IW'(p);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_row_scheduler.sv
// Picks one port-FIFO head per cycle for EasySDRAM, favouring the open row
// and the current bus direction, with urgency and starvation overrides.
module sdram_row_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ROW_LSB      = DEF_ROW_LSB,
  parameter int STARVE_LIMIT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_row_scheduler_if.slave bus
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int ROW_W  = ADDR_W - ROW_LSB;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0]  LIM      = CNT_W'(STARVE_LIMIT);
  localparam logic [PORT_W-1:0] LAST_IDX = PORT_W'(NUM_PORTS - 1);

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:ROW_LSB];
  endfunction

  logic [ROW_W-1:0]     present_row;
  logic                 last_write;
  logic [PORT_W-1:0]    rr_ptr;

  logic [NUM_PORTS-1:0] row_hit;
  logic [NUM_PORTS-1:0] starved;
  logic [NUM_PORTS-1:0] m_urgent, m_starved, m_wr_hit, m_rd_hit, m_write, m_read;

  sched_class_t         sel_cls;
  logic [NUM_PORTS-1:0] sel_mask;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_any;
  logic                 slot_free;
  logic                 grant_fire;

  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_data;
  logic                 win_write;
  logic                 win_hit;

  // Per-port row comparison and starvation counter.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [CNT_W-1:0] cnt;

      assign row_hit[gi] = (row_of(bus.req_addr[gi]) == present_row);
      assign starved[gi] = (cnt == LIM);

      // Count cycles a port sits pending; cleared on grant or when idle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (!bus.req_valid[gi] || bus.req_pop[gi]) begin
          cnt <= '0;
        end else if (cnt != LIM) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign m_urgent  = bus.req_valid & bus.req_urgent;
  assign m_starved = bus.req_valid & starved;
  assign m_wr_hit  = bus.req_valid & bus.req_is_write & row_hit & {NUM_PORTS{last_write}};
  assign m_rd_hit  = bus.req_valid & ~bus.req_is_write & row_hit;
  assign m_write   = bus.req_valid & bus.req_is_write;
  assign m_read    = bus.req_valid & ~bus.req_is_write;

  // Highest-priority class that has at least one candidate.
  always_comb begin
    sel_cls = CLS_NONE;
    if (|m_urgent)       sel_cls = CLS_URGENT;
    else if (|m_starved) sel_cls = CLS_STARVED;
    else if (|m_wr_hit)  sel_cls = CLS_WR_HIT;
    else if (|m_rd_hit)  sel_cls = CLS_RD_HIT;
    else if (|m_write)   sel_cls = CLS_WRITE;
    else if (|m_read)    sel_cls = CLS_READ;
  end

  // Candidate mask of the winning class feeds the single picker.
  always_comb begin
    sel_mask = '0;
    case (sel_cls)
      CLS_URGENT:  sel_mask = m_urgent;
      CLS_STARVED: sel_mask = m_starved;
      CLS_WR_HIT:  sel_mask = m_wr_hit;
      CLS_RD_HIT:  sel_mask = m_rd_hit;
      CLS_WRITE:   sel_mask = m_write;
      CLS_READ:    sel_mask = m_read;
      default:     sel_mask = '0;
    endcase
  end

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .mask  (sel_mask),
    .start (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The output slot can take a new command when empty or draining this cycle.
  // Nothing is popped while reset is held, so FIFOs are never drained into a
  // register that is being cleared.
  assign slot_free  = ~bus.cmd_valid | bus.cmd_ready;
  assign grant_fire = rst_n & slot_free & pick_any;
  assign bus.req_pop = grant_fire ? pick_grant : '0;

  assign win_addr  = bus.req_addr[pick_idx];
  assign win_data  = bus.req_data[pick_idx];
  assign win_write = bus.req_is_write[pick_idx];
  assign win_hit   = row_hit[pick_idx];

  // Output register: load on grant, otherwise empty once accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cmd_valid    <= 1'b0;
      bus.cmd_is_write <= 1'b0;
      bus.cmd_addr     <= '0;
      bus.cmd_data     <= '0;
      bus.cmd_port     <= '0;
      bus.cmd_row_hit  <= 1'b0;
    end else if (grant_fire) begin
      bus.cmd_valid    <= 1'b1;
      bus.cmd_is_write <= win_write;
      bus.cmd_addr     <= win_addr;
      bus.cmd_data     <= win_data;
      bus.cmd_port     <= pick_idx;
      bus.cmd_row_hit  <= win_hit;
    end else if (bus.cmd_ready) begin
      bus.cmd_valid    <= 1'b0;
    end
  end

  // Track open row, bus direction and round-robin start from each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_row <= '0;
      last_write  <= 1'b1;
      rr_ptr      <= '0;
    end else if (grant_fire) begin
      present_row <= row_of(win_addr);
      last_write  <= win_write;
      rr_ptr      <= (pick_idx == LAST_IDX) ? '0 : pick_idx + PORT_W'(1);
    end
  end

endmodule

// File: tb/tb_sdram_row_scheduler.sv
// Scenario bench for sdram_row_scheduler with a per-port-class reference model.
module tb_sdram_row_scheduler;
  import sdram_sched_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int RL  = 10;
  localparam int LIM = 64;
  localparam int PW  = $clog2(NP);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_row_scheduler_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_row_scheduler #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ROW_LSB(RL), .STARVE_LIMIT(LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  sdram_cmd_t m_cmd;
  logic       m_valid;
  int         m_port;
  logic       m_hit;
  int         m_row;
  logic       m_last;
  int         m_rr;
  int         m_cnt[NP];
  int         head_mode;  // 0 keep head, 1 next row (+4), 2 random new head

  function automatic int row_of(input logic [AW-1:0] a);
    return int'(a >> RL);
  endfunction

  // Class number of one port (0 = not requesting, 1 = best).
  function automatic int port_class(input int i);
    logic hit, wr;
    if (!bus.req_valid[i]) return 0;
    if (bus.req_urgent[i]) return 1;
    if (m_cnt[i] == LIM) return 2;
    hit = (row_of(bus.req_addr[i]) == m_row);
    wr  = bus.req_is_write[i];
    if (wr && hit && m_last) return 3;
    if (!wr && hit) return 4;
    if (wr) return 5;
    return 6;
  endfunction

  function automatic int model_pick();
    int best, p;
    if (m_valid && !bus.cmd_ready) return -1;
    best = 7;
    for (int i = 0; i < NP; i++)
      if (port_class(i) != 0 && port_class(i) < best) best = port_class(i);
    if (best == 7) return -1;
    for (int k = 0; k < NP; k++) begin
      p = (m_rr + k) % NP;
      if (port_class(p) == best) return p;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] model_pop();
    int g;
    g = model_pick();
    return (g >= 0) ? NP'(1 << g) : '0;
  endfunction

  task automatic model_reset();
    m_cmd = '0; m_valid = 1'b0; m_port = 0; m_hit = 1'b0;
    m_row = 0; m_last = 1'b1; m_rr = 0;
    for (int i = 0; i < NP; i++) m_cnt[i] = 0;
  endtask

  task automatic new_head(input int i);
    int row;
    row = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32767)) : int'($urandom_range(0, 3));
    bus.req_is_write[i] = 1'($urandom_range(0, 1));
    bus.req_addr[i]     = (AW'(row) << RL) | AW'($urandom_range(0, 1023));
    bus.req_data[i]     = DW'($urandom);
  endtask

  // Compute the model's next state from the current inputs, cross the edge, commit.
  task automatic advance();
    int g, ncnt[NP];
    logic rdy;
    sdram_cmd_t ncmd;
    logic nhit;
    g   = model_pick();
    rdy = bus.cmd_ready;
    for (int i = 0; i < NP; i++)
      ncnt[i] = (!bus.req_valid[i] || i == g) ? 0 : ((m_cnt[i] < LIM) ? m_cnt[i] + 1 : LIM);
    ncmd = m_cmd;
    nhit = 1'b0;
    if (g >= 0) begin
      ncmd.is_write = bus.req_is_write[g];
      ncmd.addr     = bus.req_addr[g];
      ncmd.data     = bus.req_data[g];
      nhit          = (row_of(bus.req_addr[g]) == m_row);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) m_cnt[i] = ncnt[i];
    if (g >= 0) begin
      m_valid = 1'b1; m_cmd = ncmd; m_port = g; m_hit = nhit;
      m_row = row_of(ncmd.addr); m_last = ncmd.is_write; m_rr = (g + 1) % NP;
      if (head_mode == 1) bus.req_addr[g] = bus.req_addr[g] + (AW'(4) << RL);
      else if (head_mode == 2) new_head(g);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0; bus.req_is_write = '0; bus.req_urgent = '0;
    bus.req_addr = '0; bus.req_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.cmd_ready = 1'b1;
    head_mode = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [AW+DW+PW+2:0] outs;
    rst_n = 1'b0; clear_inputs(); bus.cmd_ready = 1'b1; head_mode = 0;
    #12;
    outs = {bus.cmd_valid, bus.cmd_is_write, bus.cmd_addr, bus.cmd_data, bus.cmd_port, bus.cmd_row_hit};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs); else n_pass++;
    n_checks++;
    if (bus.req_pop !== '0) $display("FAIL reset_pop: got %b expected 0", bus.req_pop); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; model_reset();
    for (int c = 0; c < 3; c++) begin
      #3;
      n_checks++;
      if ({bus.cmd_valid, bus.req_pop} !== '0)
        $display("FAIL idle: got valid=%b pop=%b expected valid=0 pop=0", bus.cmd_valid, bus.req_pop);
      else n_pass++;
      advance();
    end
    // In-flight command, then asynchronous reset between edges.
    bus.req_valid[2] = 1'b1; bus.req_addr[2] = 25'h1234; bus.req_data[2] = 16'hbeef;
    bus.cmd_ready = 1'b0;
    #3;
    n_checks++;
    if (bus.req_pop !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", bus.req_pop); else n_pass++;
    advance();
    #3;
    n_checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== 25'h1234)
      $display("FAIL cmd_loaded: got valid=%b addr=%h expected valid=1 addr=1234", bus.cmd_valid, bus.cmd_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_addr !== '0)
      $display("FAIL async_reset: got valid=%b addr=%h expected valid=0 addr=0", bus.cmd_valid, bus.cmd_addr);
    else n_pass++;
    n_checks++;
    if (bus.req_pop !== '0) $display("FAIL pop_in_reset: got %b expected 0", bus.req_pop); else n_pass++;
    @(posedge clk); #1;
    clear_inputs(); bus.cmd_ready = 1'b1; rst_n = 1'b1; model_reset();
  endtask

  task automatic test_row_affinity();
    do_reset();
    bus.req_valid = 4'b0001; bus.req_is_write[0] = 1'b1; bus.req_addr[0] = 25'h000400;
    #3;
    n_checks++;
    if (bus.req_pop !== 4'b0001) $display("FAIL affinity_first: got %b expected 0001", bus.req_pop); else n_pass++;
    advance();
    bus.req_valid = 4'b0110;
    bus.req_is_write[1] = 1'b0; bus.req_addr[1] = 25'h000800;
    bus.req_is_write[2] = 1'b1; bus.req_addr[2] = 25'h000410; bus.req_data[2] = 16'h5a5a;
    #3;
    n_checks++;
    if (bus.req_pop !== 4'b0100) $display("FAIL affinity_pick: got %b expected 0100", bus.req_pop); else n_pass++;
    advance();
    bus.req_valid = 4'b0010;
    #3;
    n_checks++;
    if (bus.cmd_port !== 2'd2 || bus.cmd_row_hit !== 1'b1 || bus.cmd_addr !== 25'h000410 || bus.cmd_is_write !== 1'b1)
      $display("FAIL affinity_cmd: got port=%0d hit=%b addr=%h wr=%b expected port=2 hit=1 addr=000410 wr=1",
               bus.cmd_port, bus.cmd_row_hit, bus.cmd_addr, bus.cmd_is_write);
    else n_pass++;
    advance();
  endtask

  task automatic test_urgency();
    do_reset();
    bus.req_valid = 4'b0001; bus.req_is_write[0] = 1'b1; bus.req_addr[0] = 25'h000400;
    #3; advance();
    bus.req_valid = 4'b1001;
    bus.req_is_write[3] = 1'b0; bus.req_addr[3] = 25'h003000; bus.req_urgent[3] = 1'b1;
    #3;
    n_checks++;
    if (bus.req_pop !== 4'b1000) $display("FAIL urgent_pick: got %b expected 1000", bus.req_pop); else n_pass++;
    advance();
    bus.req_valid = 4'b0001; bus.req_urgent = '0;
    #3;
    n_checks++;
    if (bus.cmd_port !== 2'd3 || bus.cmd_row_hit !== 1'b0)
      $display("FAIL urgent_cmd: got port=%0d hit=%b expected port=3 hit=0", bus.cmd_port, bus.cmd_row_hit);
    else n_pass++;
    n_checks++;
    if (bus.req_pop !== 4'b0001) $display("FAIL urgent_after: got %b expected 0001", bus.req_pop); else n_pass++;
    advance();
  endtask

  task automatic test_starvation();
    int found;
    int gaps;
    do_reset();
    bus.req_valid = 4'b0011;
    bus.req_is_write[0] = 1'b1; bus.req_addr[0] = 25'h000400;
    bus.req_is_write[1] = 1'b0; bus.req_addr[1] = 25'h000800;
    found = -1; gaps = 0;
    for (int k = 0; k < 100; k++) begin
      #3;
      if (bus.req_pop[1]) begin
        found = k;
        break;
      end
      if (bus.req_pop !== 4'b0001) gaps++;
      advance();
    end
    n_checks++;
    if (found != LIM) $display("FAIL starve_cycle: got %0d expected %0d", found, LIM); else n_pass++;
    n_checks++;
    if (gaps != 0) $display("FAIL starve_stream: got %0d gaps expected 0", gaps); else n_pass++;
    advance();
  endtask

  task automatic test_backpressure();
    logic [NP-1:0] ep;
    do_reset();
    head_mode = 2;
    for (int i = 0; i < NP; i++) new_head(i);
    bus.req_valid = '1;
    bus.cmd_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #3;
      ep = model_pop();
      n_checks++;
      if (bus.req_pop !== ep || (c > 0 && bus.req_pop !== '0))
        $display("FAIL stall_pop[%0d]: got %b expected %b", c, bus.req_pop, ep);
      else n_pass++;
      if (c > 0) begin
        n_checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== m_cmd.addr || bus.cmd_data !== m_cmd.data || bus.cmd_port !== PW'(m_port))
          $display("FAIL stall_cmd[%0d]: got v=%b a=%h d=%h p=%0d expected v=1 a=%h d=%h p=%0d", c,
                   bus.cmd_valid, bus.cmd_addr, bus.cmd_data, bus.cmd_port, m_cmd.addr, m_cmd.data, m_port);
        else n_pass++;
      end
      advance();
    end
    bus.cmd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #3;
      ep = model_pop();
      n_checks++;
      if (bus.req_pop !== ep || $countones(bus.req_pop) != 1)
        $display("FAIL release_pop[%0d]: got %b expected %b", c, bus.req_pop, ep);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    head_mode = 1;
    for (int i = 0; i < NP; i++) bus.req_addr[i] = AW'(i + 1) << RL;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #3;
      n_checks++;
      if (bus.req_pop !== NP'(1 << order[k]))
        $display("FAIL rr_order[%0d]: got %b expected port %0d", k, bus.req_pop, order[k]);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] ep;
    do_reset();
    head_mode = 2;
    for (int i = 0; i < NP; i++) new_head(i);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        bus.req_valid[i]  = ($urandom_range(0, 3) != 0);
        bus.req_urgent[i] = ($urandom_range(0, 15) == 0);
      end
      bus.cmd_ready = ($urandom_range(0, 9) < 7);
      #3;
      ep = model_pop();
      n_checks++;
      if (bus.req_pop !== ep) $display("FAIL rand_pop[%0d]: got %b expected %b", c, bus.req_pop, ep);
      else n_pass++;
      n_checks++;
      if (bus.cmd_valid !== m_valid) $display("FAIL rand_valid[%0d]: got %b expected %b", c, bus.cmd_valid, m_valid);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (bus.cmd_is_write !== m_cmd.is_write || bus.cmd_addr !== m_cmd.addr || bus.cmd_data !== m_cmd.data ||
            bus.cmd_port !== PW'(m_port) || bus.cmd_row_hit !== m_hit)
          $display("FAIL rand_cmd[%0d]: got w=%b a=%h d=%h p=%0d h=%b expected w=%b a=%h d=%h p=%0d h=%b", c,
                   bus.cmd_is_write, bus.cmd_addr, bus.cmd_data, bus.cmd_port, bus.cmd_row_hit,
                   m_cmd.is_write, m_cmd.addr, m_cmd.data, m_port, m_hit);
        else n_pass++;
      end
      advance();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_row_affinity();
    test_urgency();
    test_starvation();
    test_backpressure();
    test_round_robin();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_row_scheduler.md
# sdram_row_scheduler

- Arbitrates SDRAM command requests from up to NUM_PORTS first-word-fall-through command FIFOs (camera, VGA, general-purpose, custom) into the single EasySDRAM command input.
- Prefers commands that keep the open row and the bus direction, which minimises precharge/activate and read→write turnaround.
- Guarantees forward progress with urgency flags and per-port starvation counters.
- Sits between the port FIFOs and EasySDRAM, replacing inline priority logic; output is registered with a valid/ready handshake.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- ADDR_W, 25, SDRAM word address width
- DATA_W, 16, write data width
- ROW_LSB, 10, lowest address bit of the row/bank field; row = addr[ADDR_W-1:ROW_LSB]
- STARVE_LIMIT, 64, wait cycles before a pending port is treated as starved (≤255)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_PORTS  FIFO head valid (~empty) per port
- req_is_write  in  NUM_PORTS  head command is a write
- req_addr  in  NUM_PORTS×ADDR_W  head address
- req_data  in  NUM_PORTS×DATA_W  head write data (don't-care for reads)
- req_urgent  in  NUM_PORTS  port FIFO past its threshold
- req_pop  out  NUM_PORTS  one-hot read strobe to the granted FIFO
- cmd_valid  out  1  output register holds a command
- cmd_ready  in  1  EasySDRAM accepts (~full)
- cmd_is_write  out  1  command type
- cmd_addr  out  ADDR_W  command address
- cmd_data  out  DATA_W  write data
- cmd_port  out  $clog2(NUM_PORTS)  source port index of the command
- cmd_row_hit  out  1  command matched the tracked row when selected

## Operation
- Slot is free when ~cmd_valid | cmd_ready. Selection happens only when the slot is free and some req_valid is set.
- Selection class order, first non-empty class wins:
  1. valid & urgent
  2. valid & starved
  3. write, row hit, last_write=1
  4. read, row hit
  5. write
  6. read
- Row hit: req_addr row == present_row.
- Within a class, the winner is the first set bit scanning upward from rr_ptr, with wrap.
- On grant g:
  - req_pop[g]=1 for exactly that cycle.
  - The output register loads g's fields.
  - present_row ← row(g); last_write ← is_write(g); rr_ptr ← (g+1) mod NUM_PORTS.
- Starvation counter per port:
  - Cleared when the port is granted or not valid.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - Starved ⇔ counter == STARVE_LIMIT.
- cmd_row_hit is computed against present_row before that grant's update.
- Reset values: cmd_valid 0, cmd_* 0, req_pop 0, present_row 0, last_write 1, rr_ptr 0, all counters 0.

## Timing
- Latency: req_valid sampled at edge N → req_pop high during cycle N (combinational from registered state and inputs) → cmd_valid high after edge N+1.
- Throughput: one command per cycle while cmd_ready stays high.
- Backpressure: cmd_valid=1 & cmd_ready=0 → output fields frozen, req_pop all 0, counters of pending ports keep incrementing.
- Simultaneous accept and new grant in one cycle is required (no bubble).
- A port whose req_valid drops at the same edge is never popped; req_pop is only ever asserted with req_valid.
- Async reset mid-transfer clears the output register. An in-flight command is discarded; upstream FIFOs are expected to be reset together.
- present_row wraps with no special case. A rr_ptr wrap from NUM_PORTS-1 goes to 0.

## Structure
- Package sdram_sched_pkg:
  - sdram_cmd_t struct {is_write, addr, data}
  - class enum CLS_URGENT..CLS_READ
  - default ROW_LSB
- Sub-module rr_pick:
  - Purpose: rotating-priority one-hot picker.
  - Inputs: mask[NUM_PORTS], start index.
  - Outputs: one-hot grant, index, any.
  - Instantiate it once, fed with the mask of the first non-empty class.

## Test plan
- Reset, then all ports idle → cmd_valid=0, req_pop=0; rst_n low mid-command → cmd_valid=0 immediately.
- Row affinity: port0 write to 0x000400 granted → present_row=1. Next, port1 read 0x000800 and port2 write 0x000410 are both valid → port2 granted, cmd_row_hit=1.
- Urgency: port3 read to a new row with req_urgent=1, and port0 row-hit write both valid → port3 granted first.
- Starvation: port1 valid on a different row while port0 streams row hits. Port1 is granted exactly when its counter reaches 64 (STARVE_LIMIT), i.e. within 66 cycles.
- Backpressure: hold cmd_ready=0 for 10 cycles with all ports valid → cmd_* stable, no req_pop. Release → one pop per cycle with no gap.
- Round-robin: all four ports issue equal-class reads to distinct rows, urgent=0 → grant order 0,1,2,3,0.
